// File: rtl/lc3b_control.sv
// lc3b_control -- Moore control FSM for the LC-3b datapath.
// Sequences fetch/decode/execute for BR, ADD, AND, NOT, LDR and STR and
// handshakes with memory through mem_read/mem_write/mem_resp.
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   opcode, imm_sel     IR[15:12] and IR[5] from the datapath
//   branch_enable       nzp/CC match from the datapath
//   mem_resp            one-cycle memory completion pulse
//   load_*/..._sel      datapath register loads and mux selects
//   aluop               000 add, 001 and, 010 not, 011 pass
//   mem_read/mem_write  memory strobes, mem_byte_enable = 11 while either is high
//   mem_error           one-cycle pulse after a memory timeout abort
// MEM_TIMEOUT = 0 waits forever for mem_resp; >0 bounds every wait state.
module lc3b_control #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] opcode,
  input  logic       imm_sel,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       pcmux_sel,
  output logic       storemux_sel,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_cc,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic       alumux_sel,
  output logic       regfilemux_sel,
  output logic [2:0] aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable,
  output logic       mem_error
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    S_ADD, S_AND, S_NOT, S_BR, BR_TAKEN,
    CALC_ADDR, LDR1, LDR2, STR1, STR2
  } state_t;

  typedef struct packed {
    logic       load_pc;
    logic       pcmux_sel;
    logic       storemux_sel;
    logic       load_ir;
    logic       load_regfile;
    logic       load_cc;
    logic       load_mar;
    logic       load_mdr;
    logic       marmux_sel;
    logic       mdrmux_sel;
    logic       alumux_sel;
    logic       regfilemux_sel;
    logic [2:0] aluop;
    logic       mem_read;
    logic       mem_write;
  } ctl_t;

  state_t          state, next_state;
  logic [CW-1:0]   wait_cnt;
  logic            err_q;
  logic            in_wait;
  logic            timeout;
  ctl_t            ctl;

  assign in_wait = (state == FETCH2) || (state == LDR1) || (state == STR2);

  // wait_cnt counts wait cycles already spent without mem_resp, so the
  // MEM_TIMEOUT-th silent cycle is the one where wait_cnt+1 hits the limit.
  // A mem_resp on that same cycle takes priority over the abort.
  always_comb begin
    timeout = 1'b0;
    if (MEM_TIMEOUT > 0 && in_wait && !mem_resp)
      timeout = (32'(wait_cnt) + 32'd1) == 32'(MEM_TIMEOUT);
  end

  // State register, wait counter and the registered error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FETCH1;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= next_state;
      err_q    <= timeout;
      // Staying put in a wait state means no mem_resp this cycle; any other
      // transition clears the counter so the next wait starts from zero.
      if (in_wait && next_state == state)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      FETCH1:    next_state = FETCH2;
      FETCH2:    if (mem_resp) next_state = FETCH3;
                 else if (timeout) next_state = FETCH1;
      FETCH3:    next_state = DECODE;
      DECODE: begin
        unique case (opcode)
          4'b0001:          next_state = S_ADD;
          4'b0101:          next_state = S_AND;
          4'b1001:          next_state = S_NOT;
          4'b0000:          next_state = S_BR;
          4'b0110, 4'b0111: next_state = CALC_ADDR;
          default:          next_state = FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT: next_state = FETCH1;
      S_BR:      next_state = branch_enable ? BR_TAKEN : FETCH1;
      BR_TAKEN:  next_state = FETCH1;
      CALC_ADDR: next_state = (opcode == 4'b0111) ? STR1 : LDR1;
      LDR1:      if (mem_resp) next_state = LDR2;
                 else if (timeout) next_state = FETCH1;
      LDR2:      next_state = FETCH1;
      STR1:      next_state = STR2;
      STR2:      if (mem_resp || timeout) next_state = FETCH1;
      default:   next_state = FETCH1;
    endcase
  end

  // Output decode: everything not named for a state stays 0.
  always_comb begin
    ctl = '0;
    unique case (state)
      FETCH1: begin
        ctl.marmux_sel = 1'b1;
        ctl.load_mar   = 1'b1;
        ctl.load_pc    = 1'b1;
      end
      FETCH2, LDR1: begin
        ctl.mem_read   = 1'b1;
        ctl.mdrmux_sel = 1'b1;
        ctl.load_mdr   = 1'b1;
      end
      FETCH3: ctl.load_ir = 1'b1;
      S_ADD, S_AND: begin
        ctl.aluop        = (state == S_AND) ? 3'b001 : 3'b000;
        ctl.alumux_sel   = imm_sel;
        ctl.load_regfile = 1'b1;
        ctl.load_cc      = 1'b1;
      end
      S_NOT: begin
        ctl.aluop        = 3'b010;
        ctl.load_regfile = 1'b1;
        ctl.load_cc      = 1'b1;
      end
      BR_TAKEN: begin
        ctl.pcmux_sel = 1'b1;
        ctl.load_pc   = 1'b1;
      end
      CALC_ADDR: begin
        ctl.alumux_sel = 1'b1;
        ctl.load_mar   = 1'b1;
      end
      LDR2: begin
        ctl.regfilemux_sel = 1'b1;
        ctl.load_regfile   = 1'b1;
        ctl.load_cc        = 1'b1;
      end
      STR1: begin
        ctl.storemux_sel = 1'b1;
        ctl.aluop        = 3'b011;
        ctl.load_mdr     = 1'b1;
      end
      STR2: begin
        ctl.storemux_sel = 1'b1;
        ctl.mem_write    = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  // Gating with reset_n forces every strobe low the moment reset asserts,
  // so an in-flight access cannot complete a write after reset.
  always_comb begin
    load_pc         = reset_n & ctl.load_pc;
    pcmux_sel       = reset_n & ctl.pcmux_sel;
    storemux_sel    = reset_n & ctl.storemux_sel;
    load_ir         = reset_n & ctl.load_ir;
    load_regfile    = reset_n & ctl.load_regfile;
    load_cc         = reset_n & ctl.load_cc;
    load_mar        = reset_n & ctl.load_mar;
    load_mdr        = reset_n & ctl.load_mdr;
    marmux_sel      = reset_n & ctl.marmux_sel;
    mdrmux_sel      = reset_n & ctl.mdrmux_sel;
    alumux_sel      = reset_n & ctl.alumux_sel;
    regfilemux_sel  = reset_n & ctl.regfilemux_sel;
    aluop           = reset_n ? ctl.aluop : 3'b000;
    mem_read        = reset_n & ctl.mem_read;
    mem_write       = reset_n & ctl.mem_write;
    mem_byte_enable = (mem_read || mem_write) ? 2'b11 : 2'b00;
    mem_error       = reset_n & err_q;
  end

endmodule

// File: tb/tb_lc3b_control.sv
// Scoreboard bench for lc3b_control: a per-instruction reference model
// expands each instruction into its expected cycle-by-cycle output trace;
// the driver plays it and queues the expectations, a monitor compares.
module tb_lc3b_control;

  localparam int TMO = 8;

  typedef struct packed {
    logic       load_pc;
    logic       pcmux_sel;
    logic       storemux_sel;
    logic       load_ir;
    logic       load_regfile;
    logic       load_cc;
    logic       load_mar;
    logic       load_mdr;
    logic       marmux_sel;
    logic       mdrmux_sel;
    logic       alumux_sel;
    logic       regfilemux_sel;
    logic [2:0] aluop;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
    logic       mem_error;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       imm_sel = 1'b0;
  logic       branch_enable = 1'b0;
  logic       mem_resp = 1'b0;
  logic       load_pc, pcmux_sel, storemux_sel, load_ir, load_regfile, load_cc;
  logic       load_mar, load_mdr, marmux_sel, mdrmux_sel, alumux_sel, regfilemux_sel;
  logic [2:0] aluop;
  logic       mem_read, mem_write, mem_error;
  logic [1:0] mem_byte_enable;
  outs_t      act;

  int total = 0;
  int bad   = 0;

  outs_t exp_q[$];
  string tag_q[$];
  outs_t exp_seq[$];
  bit    resp_seq[$];
  bit    pend_err = 0;
  string cur_tag;

  lc3b_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .imm_sel(imm_sel),
    .branch_enable(branch_enable), .mem_resp(mem_resp),
    .load_pc(load_pc), .pcmux_sel(pcmux_sel), .storemux_sel(storemux_sel),
    .load_ir(load_ir), .load_regfile(load_regfile), .load_cc(load_cc),
    .load_mar(load_mar), .load_mdr(load_mdr), .marmux_sel(marmux_sel),
    .mdrmux_sel(mdrmux_sel), .alumux_sel(alumux_sel),
    .regfilemux_sel(regfilemux_sel), .aluop(aluop), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_error(mem_error)
  );

  assign act = {load_pc, pcmux_sel, storemux_sel, load_ir, load_regfile, load_cc,
                load_mar, load_mdr, marmux_sel, mdrmux_sel, alumux_sel,
                regfilemux_sel, aluop, mem_read, mem_write, mem_byte_enable,
                mem_error};

  always #5 clk = ~clk;

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outs_t e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", t, act, e);
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic add(input outs_t o, input bit r);
    if (pend_err) begin
      o.mem_error = 1'b1;
      pend_err = 0;
    end
    exp_seq.push_back(o);
    resp_seq.push_back(r);
  endtask

  // Memory wait: resp arrives on wait cycle d (0-based). If the limit runs
  // out first, the wait lasts TMO cycles and the next cycle flags an error.
  task automatic mem_wait(input outs_t o, input int d, output bit aborted);
    int n;
    n = (d < TMO) ? d + 1 : TMO;
    for (int i = 0; i < n; i++) add(o, i == d);
    aborted = (d >= TMO);
    if (aborted) pend_err = 1;
  endtask

  task automatic build(input logic [3:0] op, input bit br, input bit imm,
                       input int d1, input int d2);
    outs_t o;
    bit ab;
    o = '0; o.marmux_sel = 1; o.load_mar = 1; o.load_pc = 1;
    add(o, 1'($urandom_range(0, 1)));
    o = '0; o.mem_read = 1; o.mdrmux_sel = 1; o.load_mdr = 1; o.mem_byte_enable = 2'b11;
    mem_wait(o, d1, ab);
    if (ab) return;
    o = '0; o.load_ir = 1; add(o, 1'($urandom_range(0, 1)));
    o = '0; add(o, 1'($urandom_range(0, 1)));
    case (op)
      4'b0001, 4'b0101: begin
        o = '0; o.aluop = (op == 4'b0101) ? 3'd1 : 3'd0; o.alumux_sel = imm;
        o.load_regfile = 1; o.load_cc = 1; add(o, 1'($urandom_range(0, 1)));
      end
      4'b1001: begin
        o = '0; o.aluop = 3'd2; o.load_regfile = 1; o.load_cc = 1;
        add(o, 1'($urandom_range(0, 1)));
      end
      4'b0000: begin
        o = '0; add(o, 1'($urandom_range(0, 1)));
        if (br) begin
          o = '0; o.pcmux_sel = 1; o.load_pc = 1; add(o, 1'($urandom_range(0, 1)));
        end
      end
      4'b0110, 4'b0111: begin
        o = '0; o.alumux_sel = 1; o.load_mar = 1; add(o, 1'($urandom_range(0, 1)));
        if (op == 4'b0110) begin
          o = '0; o.mem_read = 1; o.mdrmux_sel = 1; o.load_mdr = 1; o.mem_byte_enable = 2'b11;
          mem_wait(o, d2, ab);
          if (!ab) begin
            o = '0; o.regfilemux_sel = 1; o.load_regfile = 1; o.load_cc = 1;
            add(o, 1'($urandom_range(0, 1)));
          end
        end else begin
          o = '0; o.storemux_sel = 1; o.aluop = 3'd3; o.load_mdr = 1;
          add(o, 1'($urandom_range(0, 1)));
          o = '0; o.storemux_sel = 1; o.mem_write = 1; o.mem_byte_enable = 2'b11;
          mem_wait(o, d2, ab);
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic play(input logic [3:0] op, input bit br, input bit imm, input int n);
    for (int i = 0; i < exp_seq.size() && i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        opcode = op; branch_enable = br; imm_sel = imm;
      end
      reset_n  = 1'b1;
      mem_resp = resp_seq[i];
      exp_q.push_back(exp_seq[i]);
      tag_q.push_back($sformatf("%s[%0d]", cur_tag, i));
    end
    exp_seq.delete();
    resp_seq.delete();
  endtask

  task automatic instr(input string t, input logic [3:0] op, input bit br,
                       input bit imm, input int d1, input int d2);
    cur_tag = t;
    build(op, br, imm, d1, d2);
    play(op, br, imm, 1000);
  endtask

  task automatic rst_step(input string t);
    @(posedge clk); #1;
    reset_n  = 1'b0;
    mem_resp = 1'($urandom_range(0, 1));
    exp_q.push_back('0);
    tag_q.push_back(t);
  endtask

  initial begin
    // Reset held for 3 cycles: all outputs low.
    for (int i = 0; i < 3; i++) rst_step("reset");
    pend_err = 0;

    instr("add_imm",   4'b0001, 0, 1, 1, 0);
    instr("and_reg",   4'b0101, 0, 0, 0, 0);
    instr("not",       4'b1001, 0, 0, 2, 0);
    instr("br_taken",  4'b0000, 1, 0, 0, 0);
    instr("br_not",    4'b0000, 0, 0, 0, 0);
    instr("str_dly4",  4'b0111, 0, 0, 0, 4);
    instr("ldr",       4'b0110, 0, 0, 0, 2);
    instr("fetch_tmo", 4'b0001, 0, 0, 8, 0);   // no resp: abort after 8 cycles
    instr("resp_at8",  4'b0001, 0, 0, 7, 0);   // resp on the 8th cycle wins
    instr("ldr_tmo",   4'b0110, 0, 0, 0, 9);
    instr("str_tmo",   4'b0111, 0, 0, 1, 8);
    instr("nop_op",    4'b1111, 0, 0, 0, 0);

    // Reset in the middle of LDR1: outputs drop immediately.
    cur_tag = "ldr_cut";
    build(4'b0110, 0, 0, 0, 5);
    play(4'b0110, 0, 0, 7);
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_q.push_back('0);
    tag_q.push_back("mid_ldr_reset");
    #1;
    total++;
    if (act !== '0) begin
      bad++;
      $display("FAIL async_reset_outs: got %h want %h", act, outs_t'('0));
    end
    rst_step("mid_ldr_reset_hold");
    pend_err = 0;
    instr("after_reset", 4'b0001, 0, 0, 0, 0);

    // Randomized instruction stream.
    for (int k = 0; k < 80; k++) begin
      logic [3:0] op;
      int d1, d2;
      op = 4'($urandom_range(0, 15));
      d1 = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 9) : $urandom_range(0, 3);
      d2 = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 9) : $urandom_range(0, 3);
      instr($sformatf("rnd%0d_op%h", k, op), op, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), d1, d2);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
